// File: rtl/note_dispatch_scheduler_if.sv
// Handshake/bus bundle between the note scheduler, its event producer,
// the external us timer and the note consumer.
interface note_dispatch_scheduler_if #(
  parameter int TIME_BITS = 29,
  parameter int NOTE_BITS = 7,
  parameter int DEPTH     = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 cmd_start;
  logic                 cmd_pause;
  logic                 cmd_stop;
  logic                 ev_valid;
  logic                 ev_ready;
  logic [TIME_BITS-1:0] ev_time;
  logic [NOTE_BITS-1:0] ev_note;
  logic [TIME_BITS-1:0] now_us;
  logic                 timer_enable;
  logic                 timer_clear;
  logic                 note_valid;
  logic [NOTE_BITS-1:0] note_id;
  logic                 note_late;
  logic [CNT_W-1:0]     queue_count;
  logic [1:0]           state;
  logic                 done;

  modport master (
    output cmd_start, cmd_pause, cmd_stop, ev_valid, ev_time, ev_note, now_us,
    input  ev_ready, timer_enable, timer_clear, note_valid, note_id, note_late,
    input  queue_count, state, done
  );

  modport slave (
    input  cmd_start, cmd_pause, cmd_stop, ev_valid, ev_time, ev_note, now_us,
    output ev_ready, timer_enable, timer_clear, note_valid, note_id, note_late,
    output queue_count, state, done
  );
endinterface

// File: rtl/note_dispatch_scheduler.sv
// Timestamped note queue released against an external us timer, plus the
// timer's run/pause/stop/session-limit sequencing. Optional macro: LATE_FLAG_EN.
module note_dispatch_scheduler #(
  parameter int TIME_BITS  = 29,
  parameter int NOTE_BITS  = 7,
  parameter int DEPTH      = 16,
  parameter int TIME_LIMIT = 300000000,
  parameter int LATE_TOL   = 2000
) (
  input logic                   clk,
  input logic                   resetn,
  note_dispatch_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 2) || (LATE_TOL < 0)) begin : g_param_check
    $error("note_dispatch_scheduler: DEPTH must be a power of 2 >= 2, LATE_TOL >= 0");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic                 clear_d, flush_d;
  logic [TIME_BITS-1:0] mem_time [DEPTH];
  logic [NOTE_BITS-1:0] mem_note [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 timer_enable_q, timer_clear_q, blank_q;
  logic                 note_valid_q, note_late_q, done_q;
  logic [NOTE_BITS-1:0] note_id_q;
  logic                 ev_ready_s, limit_s, due_s, push_s, pop_s, late_s;
  logic [TIME_BITS-1:0] head_time_s;
  logic [NOTE_BITS-1:0] head_note_s;

  assign head_time_s = mem_time[rd_ptr_q];
  assign head_note_s = mem_note[rd_ptr_q];
  assign ev_ready_s  = (count_q < CNT_W'(DEPTH)) && (state_q != S_DONE);
  assign limit_s     = (bus.now_us >= TIME_BITS'(TIME_LIMIT));
  assign due_s       = (count_q != {CNT_W{1'b0}}) && (bus.now_us >= head_time_s);

`ifdef LATE_FLAG_EN
  logic [TIME_BITS-1:0] lateness_s;
  assign lateness_s = bus.now_us - head_time_s;
  assign late_s     = (lateness_s > TIME_BITS'(LATE_TOL));
`else
  assign late_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: stop beats everything; start/pause only act where legal
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    flush_d = 1'b0;
    if (bus.cmd_stop) begin
      state_d = S_IDLE;
      clear_d = 1'b1;
      flush_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.cmd_start) begin
            state_d = S_RUN;
            clear_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        S_RUN: begin
          if (limit_s) begin
            state_d = S_DONE;
            flush_d = 1'b1;
          end else if (bus.cmd_pause) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_RUN;
          end
        end
        S_PAUSE: begin
          if (bus.cmd_start) begin
            state_d = S_RUN;
          end else begin
            state_d = S_PAUSE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Dispatch is blanked while now_us still reflects the pre-clear count
  always_comb begin
    pop_s  = 1'b0;
    push_s = bus.ev_valid && ev_ready_s && !flush_d;
    if ((state_q == S_RUN) && !bus.cmd_stop && !timer_clear_q && !blank_q && due_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else if (flush_d) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Event storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_time[wr_ptr_q] <= bus.ev_time;
      mem_note[wr_ptr_q] <= bus.ev_note;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_enable_q <= 1'b0;
      timer_clear_q  <= 1'b0;
      blank_q        <= 1'b0;
      note_valid_q   <= 1'b0;
      note_id_q      <= {NOTE_BITS{1'b0}};
      note_late_q    <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      timer_enable_q <= (state_d == S_RUN);
      timer_clear_q  <= clear_d;
      blank_q        <= timer_clear_q;
      note_valid_q   <= pop_s;
      note_id_q      <= pop_s ? head_note_s : note_id_q;
      note_late_q    <= pop_s && late_s;
      done_q         <= (state_d == S_DONE);
    end
  end

  assign bus.ev_ready     = ev_ready_s;
  assign bus.timer_enable = timer_enable_q;
  assign bus.timer_clear  = timer_clear_q;
  assign bus.note_valid   = note_valid_q;
  assign bus.note_id      = note_id_q;
  assign bus.note_late    = note_late_q;
  assign bus.queue_count  = count_q;
  assign bus.state        = state_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_note_dispatch_scheduler.sv
// Directed bench for note_dispatch_scheduler with a behavioural us timer and
// a dispatch scoreboard (expected note, timer value at the strobe, late flag).
module tb_note_dispatch_scheduler;
  localparam int TB = 29;
  localparam int NB = 7;
  localparam int D  = 16;
`ifdef LATE_FLAG_EN
  localparam logic LATE_ON = 1'b1;
`else
  localparam logic LATE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [TB-1:0] now_r = '0;
  always #5 clk = ~clk;

  note_dispatch_scheduler_if #(.TIME_BITS(TB), .NOTE_BITS(NB), .DEPTH(D)) bus ();

  note_dispatch_scheduler #(
    .TIME_BITS(TB), .NOTE_BITS(NB), .DEPTH(D), .TIME_LIMIT(100), .LATE_TOL(20)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  // External free-running timer: clear wins over enable
  always @(posedge clk) begin
    if (bus.timer_clear) now_r <= '0;
    else if (bus.timer_enable) now_r <= now_r + 29'd1;
  end
  assign bus.now_us = now_r;

  typedef struct packed {
    logic [NB-1:0] note;
    logic [TB-1:0] at;
    logic          late;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (resetn && bus.note_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_dispatch: note_id %0d at now_us %0d, nothing expected", bus.note_id, bus.now_us);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("note_id", 32'(bus.note_id), 32'(e.note));
        chk("dispatch_time", 32'(bus.now_us), 32'(e.at));
        chk("note_late", 32'(bus.note_late), 32'(e.late));
      end
    end
  end

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0:       bus.cmd_start = 1'b1;
      1:       bus.cmd_pause = 1'b1;
      default: bus.cmd_stop  = 1'b1;
    endcase
    @(negedge clk);
    bus.cmd_start = 1'b0;
    bus.cmd_pause = 1'b0;
    bus.cmd_stop  = 1'b0;
  endtask

  task automatic wait_now(input logic [TB-1:0] v);
    @(negedge clk);
    for (int i = 0; i < 500 && bus.now_us != v; i++) @(negedge clk);
    if (bus.now_us != v) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_now: now_us %0d never reached %0d", bus.now_us, v);
    end
  endtask

  task automatic push(input logic [TB-1:0] t, input logic [NB-1:0] n,
                      input bit track, input logic [TB-1:0] at, input logic late);
    exp_t e;
    if (track) begin
      e.note = n; e.at = at; e.late = late;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.ev_valid = 1'b1;
    bus.ev_time  = t;
    bus.ev_note  = n;
    for (int i = 0; i < 200 && !bus.ev_ready; i++) @(negedge clk);
    if (!bus.ev_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: ev_ready stuck at %0d for note %0d", bus.ev_ready, n);
    end
    @(posedge clk);
    #1 bus.ev_valid = 1'b0;
  endtask

  initial begin
    bus.cmd_start = 1'b0;
    bus.cmd_pause = 1'b0;
    bus.cmd_stop  = 1'b0;
    bus.ev_valid  = 1'b0;
    bus.ev_time   = '0;
    bus.ev_note   = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_count", 32'(bus.queue_count), 32'd0);
    chk("rst_ev_ready", 32'(bus.ev_ready), 32'd1);
    chk("rst_timer_enable", 32'(bus.timer_enable), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    resetn = 1'b1;

    // Basic dispatch: t=10 strobes the cycle after now_us reaches 10
    pulse(0);
    chk("start_state", 32'(bus.state), 32'd1);
    chk("start_clear", 32'(bus.timer_clear), 32'd1);
    chk("start_enable", 32'(bus.timer_enable), 32'd1);
    push(29'd10, 7'd60, 1'b1, 29'd11, 1'b0);
    wait_now(29'd14);
    chk("note_id_held", 32'(bus.note_id), 32'd60);
    chk("count_after_t1", 32'(bus.queue_count), 32'd0);

    // Pause at 50 (timer counts once more on the leaving edge), resume without clear
    push(29'd60, 7'd70, 1'b1, 29'd61, 1'b0);
    wait_now(29'd49);
    pulse(1);
    chk("pause_state", 32'(bus.state), 32'd2);
    chk("pause_enable", 32'(bus.timer_enable), 32'd0);
    repeat (100) @(negedge clk);
    chk("pause_frozen_now", 32'(bus.now_us), 32'd51);
    chk("pause_count", 32'(bus.queue_count), 32'd1);
    pulse(0);
    chk("resume_state", 32'(bus.state), 32'd1);
    chk("resume_no_clear", 32'(bus.timer_clear), 32'd0);
    wait_now(29'd63);

    pulse(2);
    chk("stop_state", 32'(bus.state), 32'd0);
    chk("stop_clear", 32'(bus.timer_clear), 32'd1);
    chk("stop_enable", 32'(bus.timer_enable), 32'd0);

    // Three events due together leave on consecutive cycles
    push(29'd5, 7'd1, 1'b1, 29'd6, 1'b0);
    push(29'd5, 7'd2, 1'b1, 29'd7, 1'b0);
    push(29'd5, 7'd3, 1'b1, 29'd8, 1'b0);
    @(negedge clk);
    chk("same_time_count", 32'(bus.queue_count), 32'd3);
    pulse(0);
    wait_now(29'd10);

    // Session limit 100: DONE flushes the four undispatchable events
    for (int i = 0; i < 4; i++) push(29'd200, NB'(40 + i), 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("limit_pre_count", 32'(bus.queue_count), 32'd4);
    for (int i = 0; i < 300 && bus.state != 2'b11; i++) @(negedge clk);
    chk("done_state", 32'(bus.state), 32'd3);
    chk("done_now", 32'(bus.now_us), 32'd101);
    chk("done_count", 32'(bus.queue_count), 32'd0);
    chk("done_flag", 32'(bus.done), 32'd1);
    chk("done_ev_ready", 32'(bus.ev_ready), 32'd0);
    chk("done_enable", 32'(bus.timer_enable), 32'd0);
    pulse(2);
    chk("done_stop_state", 32'(bus.state), 32'd0);
    chk("done_stop_clear", 32'(bus.timer_clear), 32'd1);
    chk("done_stop_done", 32'(bus.done), 32'd0);
    chk("done_stop_ready", 32'(bus.ev_ready), 32'd1);

    // Fill to DEPTH in IDLE; 17th waits for the first pop. Clear blanking puts
    // the first decision at now_us=1, so event t=k strobes at now_us=k+2.
    for (int k = 0; k < 16; k++) push(TB'(k), NB'(20 + k), 1'b1, TB'(k + 2), 1'b0);
    @(negedge clk);
    chk("full_count", 32'(bus.queue_count), 32'd16);
    chk("full_ev_ready", 32'(bus.ev_ready), 32'd0);
    fork
      push(29'd16, 7'd36, 1'b1, 29'd18, 1'b0);
      begin
        repeat (5) @(negedge clk);
        chk("full_held_count", 32'(bus.queue_count), 32'd16);
        pulse(0);
      end
    join
    wait_now(29'd20);
    chk("drain_count", 32'(bus.queue_count), 32'd0);

    // Asynchronous reset mid-RUN with five events queued
    for (int i = 0; i < 5; i++) push(29'd90, NB'(50 + i), 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("pre_reset_count", 32'(bus.queue_count), 32'd5);
    #2 resetn = 1'b0;
    #1;
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_count", 32'(bus.queue_count), 32'd0);
    chk("arst_enable", 32'(bus.timer_enable), 32'd0);
    chk("arst_valid", 32'(bus.note_valid), 32'd0);
    chk("arst_note_id", 32'(bus.note_id), 32'd0);
    chk("arst_ev_ready", 32'(bus.ev_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;

    // Stale timestamp dispatches at once; late only when the flag is built in
    pulse(0);
    wait_now(29'd39);
    push(29'd0, 7'd99, 1'b1, 29'd42, LATE_ON);
    wait_now(29'd45);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
